replay_buffer_seq: RTL and testbench

//  Parametrised DLL replay buffer: stores outgoing TLPs (CRC already appended) in a circular RAM,

---
 rtl/replay_buffer_seq.sv | 164 ++++++++++++++++
 tb/tb_replay_buffer_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/replay_buffer_seq.sv
// DLL replay buffer: circular TLP store with sequence numbering, ACK purge and NAK/timeout replay.
// Optional replay timer is compiled in when REPLAY_TIMER_EN is defined.
module replay_buffer_seq #(
    parameter int DATA_W     = 128,
    parameter int DEPTH      = 8,
    parameter int SEQ_W      = 12,
    parameter int REPLAY_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_rdy,
    output logic                       tx_valid,
    output logic [DATA_W-1:0]          tx_data,
    output logic [SEQ_W-1:0]           tx_seq,
    input  logic                       tx_rdy,
    input  logic                       ack,
    input  logic                       nak,
    input  logic [SEQ_W-1:0]           ack_seq,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       replay_active,
    output logic                       replay_rollover,
    output logic                       timeout_evt
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int RN_W   = $clog2(REPLAY_MAX + 1);

    if (DEPTH < 2 || (1 << ADDR_W) != DEPTH || DEPTH >= (1 << SEQ_W) ||
        REPLAY_MAX < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("replay_buffer_seq: illegal parameter combination");
    end

    typedef enum logic {ST_SEND, ST_REPLAY} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    head, tx_ptr, tail, replay_end;
    logic [SEQ_W-1:0]    oldest_seq;
    logic [RN_W-1:0]     replay_num;
    logic                rollover_q;

    logic [PTR_W-1:0]    outstanding, tx_off, purge_head, new_head, sent_end, tx_ptr_nxt;
    logic [SEQ_W-1:0]    ack_off;
    logic [RN_W-1:0]     rn_base, rn_inc;
    logic                in_window, nak_null, ack_ok, nak_ok, purge;
    logic                replay_req, replay_start, tx_fire, wr_fire, timer_fire;

    // Pointers carry one extra bit so that a full buffer and an empty one differ.
    assign count         = tail - head;
    assign full          = (count == PTR_W'(DEPTH));
    assign empty         = (count == '0);
    assign replay_active = (state == ST_REPLAY);
    assign wr_rdy        = !full && !replay_active;
    assign tx_valid      = (tx_ptr != tail);
    assign tx_data       = mem[tx_ptr[ADDR_W-1:0]];
    assign tx_off        = tx_ptr - head;
    assign tx_seq        = oldest_seq + SEQ_W'(tx_off);
    assign replay_rollover = rollover_q;

    // ack_seq is valid when it names a sent-but-unacked entry; oldest-1 is a no-purge NAK.
    assign outstanding  = tx_ptr - head;
    assign ack_off      = ack_seq - oldest_seq;
    assign in_window    = (ack_off < SEQ_W'(outstanding));
    assign nak_null     = (ack_seq == (oldest_seq - SEQ_W'(1)));
    assign ack_ok       = ack && !nak && in_window;
    assign nak_ok       = nak && (in_window || nak_null);
    assign purge        = ack_ok || (nak && in_window);
    assign purge_head   = head + PTR_W'(ack_off) + PTR_W'(1);
    assign new_head     = purge ? purge_head : head;
    assign sent_end     = replay_active ? replay_end : tx_ptr;
    assign replay_req   = nak_ok || timer_fire;
    assign replay_start = replay_req && (new_head != sent_end);
    assign tx_fire      = tx_valid && tx_rdy;
    assign wr_fire      = wr_en && wr_rdy;
    assign tx_ptr_nxt   = replay_start ? new_head :
                          (tx_fire ? tx_ptr + PTR_W'(1) : tx_ptr);
    assign rn_base      = purge ? '0 : replay_num;
    assign rn_inc       = rn_base + RN_W'(1);

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[tail[ADDR_W-1:0]] <= wr_data;
        end
    end

    // A NAK arriving mid-replay rewinds to the new head but keeps the original replay end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_SEND;
            head       <= '0;
            tx_ptr     <= '0;
            tail       <= '0;
            replay_end <= '0;
            oldest_seq <= '0;
            replay_num <= '0;
            rollover_q <= 1'b0;
        end else begin
            rollover_q <= 1'b0;
            head       <= new_head;
            tx_ptr     <= tx_ptr_nxt;
            if (wr_fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (purge) begin
                oldest_seq <= ack_seq + SEQ_W'(1);
            end
            if (replay_start) begin
                state <= ST_REPLAY;
                if (!replay_active) begin
                    replay_end <= tx_ptr;
                end
                if (rn_inc == RN_W'(REPLAY_MAX)) begin
                    rollover_q <= 1'b1;
                    replay_num <= '0;
                end else begin
                    replay_num <= rn_inc;
                end
            end else begin
                if (purge) begin
                    replay_num <= '0;
                end
                if (replay_active && tx_ptr_nxt == replay_end) begin
                    state <= ST_SEND;
                end
            end
        end
    end

`ifdef REPLAY_TIMER_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer;
    logic             timeout_q;

    // Expiry replays without purging; any valid ACK or NAK in the same cycle takes precedence.
    assign timer_fire  = !replay_active && (head != tx_ptr) &&
                         (timer == TMR_W'(TIMEOUT)) && !nak_ok && !ack_ok;
    assign timeout_evt = timeout_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timer_fire;
            if (purge || replay_start || replay_active || head == tx_ptr) begin
                timer <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
        end
    end
`else
    assign timer_fire  = 1'b0;
    assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_replay_buffer_seq.sv
// Directed bench for replay_buffer_seq with a scoreboard of pending and sent-but-unacked TLPs.
// Timer checks adapt to whether REPLAY_TIMER_EN is defined.
module tb_replay_buffer_seq;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int SW    = 12;
    localparam int RMAX  = 4;
    localparam int TMO   = 16;

    typedef struct packed {
        logic [SW-1:0] seq;
        logic [DW-1:0] data;
    } item_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          tx_rdy = 1'b0;
    logic          ack = 1'b0;
    logic          nak = 1'b0;
    logic [SW-1:0] ack_seq = '0;
    logic          wr_rdy, tx_valid, full, empty;
    logic          replay_active, replay_rollover, timeout_evt;
    logic [DW-1:0] tx_data;
    logic [SW-1:0] tx_seq;
    logic [3:0]    count;

    item_t         exp_q[$];
    item_t         sent_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [SW-1:0] next_seq = '0;
    logic [SW-1:0] model_oldest = '0;
    int            rnum = 0;
    int            replay_left = 0;
    logic          exp_roll = 1'b0;

    replay_buffer_seq #(
        .DATA_W(DW), .DEPTH(DEPTH), .SEQ_W(SW), .REPLAY_MAX(RMAX), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_rdy(wr_rdy),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_seq(tx_seq), .tx_rdy(tx_rdy),
        .ack(ack), .nak(nak), .ack_seq(ack_seq), .full(full), .empty(empty),
        .count(count), .replay_active(replay_active),
        .replay_rollover(replay_rollover), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int model_count();
        return exp_q.size() + sent_q.size();
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [DW-1:0] d, input logic t,
                                 input logic a, input logic n, input logic [SW-1:0] s);
        wr_en = w; wr_data = d; tx_rdy = t; ack = a; nak = n; ack_seq = s;
        @(posedge clk);
        #1;
        wr_en = 1'b0; tx_rdy = 1'b0; ack = 1'b0; nak = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic write_tlp();
        logic [DW-1:0] d;
        bit            acc;
        item_t         it;
        d   = $urandom();
        acc = (model_count() < DEPTH) && (replay_left == 0);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, '0);
        if (acc) begin
            it.seq = next_seq; it.data = d;
            exp_q.push_back(it);
            next_seq++;
        end
    endtask

    task automatic send_one();
        item_t it;
        checkOutput("tx_valid", tx_valid, 1);
        it = exp_q.pop_front();
        checkOutput("tx_seq", tx_seq, it.seq);
        checkOutput("tx_data", tx_data, it.data);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
        sent_q.push_back(it);
        if (replay_left > 0) replay_left--;
    endtask

    task automatic drain();
        while (exp_q.size() > 0) send_one();
    endtask

    function automatic bit purge_to(input logic [SW-1:0] s);
        bit found = 0;
        foreach (sent_q[i]) if (sent_q[i].seq == s) found = 1;
        if (found) begin
            while (sent_q[0].seq != s) sent_q.delete(0);
            sent_q.delete(0);
            model_oldest = s + 12'd1;
        end
        return found;
    endfunction

    // Everything sent but unacked goes back in front of the unsent entries.
    task automatic model_replay(input bit purged);
        if (purged) rnum = 0;
        rnum++;
        if (rnum == RMAX) begin
            exp_roll = 1'b1;
            rnum = 0;
        end
        replay_left = replay_left + sent_q.size();
        for (int i = sent_q.size() - 1; i >= 0; i--) exp_q.push_front(sent_q[i]);
        sent_q.delete();
    endtask

    task automatic do_ack(input logic [SW-1:0] s);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, s);
        if (purge_to(s)) rnum = 0;
        checkOutput("ack_count", count, model_count());
        checkOutput("ack_empty", empty, model_count() == 0);
    endtask

    task automatic ack_all();
        do_ack(sent_q[sent_q.size() - 1].seq);
    endtask

    task automatic do_nak(input logic [SW-1:0] s, input logic both);
        bit purged, valid;
        applyStimulus(1'b0, '0, 1'b0, both, 1'b1, s);
        exp_roll = 1'b0;
        valid  = (s == model_oldest - 12'd1);
        purged = purge_to(s);
        valid  = valid || purged;
        if (valid && sent_q.size() > 0) model_replay(purged);
        else if (purged) rnum = 0;
        checkOutput("nak_replay_active", replay_active, replay_left > 0);
        checkOutput("nak_rollover", replay_rollover, exp_roll);
        checkOutput("nak_count", count, model_count());
        checkOutput("nak_wr_rdy", wr_rdy, (replay_left == 0) && (model_count() < DEPTH));
        idle();
        checkOutput("rollover_pulse_end", replay_rollover, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        idle();
        rst = 1'b1;
        exp_q.delete(); sent_q.delete();
        next_seq = '0; model_oldest = '0; rnum = 0; replay_left = 0;
    endtask

    initial begin
        int  n;
        bit  seen;

        #1;
        do_reset();
        checkOutput("reset_wr_rdy", wr_rdy, 1);
        checkOutput("reset_empty", empty, 1);
        checkOutput("reset_full", full, 0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_tx_valid", tx_valid, 0);
        checkOutput("reset_replay_active", replay_active, 0);
        checkOutput("reset_rollover", replay_rollover, 0);
        checkOutput("reset_timeout", timeout_evt, 0);

        $display("[TB] basic write/send/ack");
        write_tlp();
        checkOutput("write_latency_tx_valid", tx_valid, 1);
        write_tlp();
        write_tlp();
        checkOutput("three_count", count, 3);
        drain();
        do_ack(12'd1);
        checkOutput("ack1_count", count, 1);
        do_ack(12'd2);

        $display("[TB] fill to full");
        for (int i = 0; i < DEPTH; i++) write_tlp();
        checkOutput("full_flag", full, 1);
        checkOutput("full_wr_rdy", wr_rdy, 0);
        write_tlp();
        checkOutput("full_count_hold", count, DEPTH);
        drain();
        ack_all();

        $display("[TB] nak with purge and replay");
        for (int i = 0; i < 5; i++) write_tlp();
        drain();
        do_nak(12'd12, 1'b0);
        checkOutput("nak_purge_count", count, 3);
        send_one();
        checkOutput("replay_mid_active", replay_active, 1);
        drain();
        checkOutput("replay_done", replay_active, 0);

        $display("[TB] replay rollover");
        do_ack(12'd13);
        for (int i = 0; i < RMAX; i++) begin
            do_nak(12'd13, 1'b0);
            drain();
        end
        for (int i = 0; i < 2; i++) begin
            do_nak(12'd13, 1'b0);
            drain();
        end
        do_ack(12'd14);
        for (int i = 0; i < RMAX; i++) begin
            do_nak(12'd14, 1'b0);
            drain();
        end
        ack_all();

        $display("[TB] invalid acks and ack+nak collision");
        for (int i = 0; i < 3; i++) write_tlp();
        drain();
        do_ack(model_oldest - 12'd2);
        do_ack(model_oldest + 12'd4);
        checkOutput("invalid_ack_count", count, 3);
        do_nak(model_oldest - 12'd1, 1'b1);
        checkOutput("collision_replay", replay_active, 1);
        drain();
        ack_all();

        $display("[TB] timer");
        write_tlp();
        send_one();
        n = 0;
        seen = 0;
`ifdef REPLAY_TIMER_EN
        while (!seen && n < 40) begin
            idle();
            n++;
            if (timeout_evt === 1'b1) seen = 1;
        end
        checkOutput("timeout_seen", seen, 1);
        checkOutput("timeout_cycle", (n >= TMO) && (n <= TMO + 1), 1);
        exp_roll = 1'b0;
        model_replay(1'b0);
        checkOutput("timeout_replay", replay_active, 1);
        drain();
`else
        for (int i = 0; i < 40; i++) begin
            idle();
            if (timeout_evt !== 1'b0) seen = 1;
        end
        checkOutput("no_timer_evt", seen, 0);
        checkOutput("no_timer_replay", replay_active, 0);
        checkOutput("no_timer_count", count, 1);
`endif
        ack_all();

        $display("[TB] reset during replay");
        write_tlp();
        write_tlp();
        drain();
        do_nak(model_oldest - 12'd1, 1'b0);
        do_reset();
        checkOutput("midreplay_count", count, 0);
        checkOutput("midreplay_active", replay_active, 0);
        checkOutput("midreplay_wr_rdy", wr_rdy, 1);
        checkOutput("midreplay_tx_valid", tx_valid, 0);

        $display("[TB] sequence wrap");
        for (int b = 0; b < 520; b++) begin
            for (int i = 0; i < DEPTH; i++) write_tlp();
            drain();
            ack_all();
        end
        checkOutput("wrap_seq", next_seq, 12'(520 * DEPTH));
        checkOutput("wrap_empty", empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
